nmr_cpmg_multiscan_seq: RTL
===========================

Name: nmr_cpmg_multiscan_seq

Overview:
Next-generation CPMG pulse-program sequencer on the PULSEPROG_CLK domain. It adds multi-scan averaging with N-phase phase cycling to the single-scan NMR controller FSM, plus optional T1 inversion-recovery preparation. Outputs are the TX gate, the RF phase select, the receiver enable and the ADC acquisition window; these drive the RF/phase mux and the ADC capture block downstream.

Parameters:
DATABUS_WIDTH, 32, width of all timing/count inputs (cycles of PULSEPROG_CLK)
PHASE_BITS, 2, phase-select width; 2^PHASE_BITS phase steps per 360 deg
SCAN_WIDTH, 16, width of NUM_SCANS and SCAN_IDX

Ports:
PULSEPROG_CLK  in  1  sole clock
RESET  in  1  synchronous, active-high reset
START  in  1  start request, level-sampled; honoured only in IDLE
ABORT  in  1  return to IDLE at next edge
T1_PULSE180, T1_DELAY, PULSE90, DELAY_NO_ACQ, PULSE180, DELAY_WITH_ACQ, ECHO_PER_SCAN, SAMPLES_PER_ECHO, RX_DELAY, ECHO_SKIP, SCAN_DELAY  in  DATABUS_WIDTH each  sequence timing/counts
NUM_SCANS  in  SCAN_WIDTH  scans per run
PHASE_CYCLE  in  1  enable phase stepping per scan
FSMSTAT  out  1  high while sequence running
TX_GATE  out  1  RF pulse gate
TX_PHASE  out  PHASE_BITS  RF phase select
EN_RX  out  1  receiver enable
ACQ_WND  out  1  ADC acquisition window
SCAN_IDX  out  SCAN_WIDTH  current scan, 0-based
SCAN_DONE  out  1  1-cycle pulse at end of each scan
DONE  out  1  1-cycle pulse at end of run
EN_QSW  out  1  Q-switch enable (see Optional Feature)

Behaviour:
- Reset: all outputs 0; FSM in IDLE; latched parameters cleared.
- Parameter latch: all timing/count inputs are latched on the edge that accepts START. Later changes are ignored until the next run.
- START is rejected (stays IDLE, no pulse) if ECHO_PER_SCAN==0 or NUM_SCANS==0.
- States: IDLE -> T1_180 -> T1_DLY -> P90 -> D_NOACQ -> {P180 -> D_ACQ} x ECHO_PER_SCAN -> SCAN_WAIT -> P90 (next scan) or IDLE.
- T1_180/T1_DLY run only when T1_PULSE180!=0. They repeat at the start of every scan.
- Each state lasts exactly its parameter in cycles. Zero PULSE90/PULSE180/DELAY_NO_ACQ/DELAY_WITH_ACQ/T1_DELAY is clamped to 1 cycle. SCAN_DELAY==0 skips SCAN_WAIT.
- Latency: START accepted at edge k; FSMSTAT and the first state's outputs are valid from edge k+1. All outputs are registered, with no combinational path from inputs.
- TX_GATE: high in T1_180, P90, P180; low elsewhere.
- TX_PHASE: scan phase ph = PHASE_CYCLE ? SCAN_IDX[PHASE_BITS-1:0] : 0.
  - P90 uses ph.
  - P180 and T1_180 use ph+1 (quadrature, mod 2^PHASE_BITS).
  - Outside pulses, TX_PHASE holds its last value.
- EN_RX: high through every D_ACQ state.
- ACQ_WND: during D_ACQ of echo e (0-based), when e >= ECHO_SKIP, high for state-counter cycles RX_DELAY .. RX_DELAY+SAMPLES_PER_ECHO-1. The window is truncated at the end of D_ACQ and never spans into P180.
- Echo and scan counters: echo counter wraps to 0 at each scan. SCAN_IDX increments on the edge leaving the last D_ACQ (or SCAN_WAIT).
- SCAN_DONE pulses in the cycle after each scan's last state.
- DONE pulses in the cycle after the last scan. In that same cycle FSMSTAT drops and SCAN_IDX resets to 0.
- ABORT (any state): next edge forces IDLE and all outputs to 0. No DONE pulse. ABORT has priority over START.
- RESET mid-run: identical to ABORT; also clears latched parameters.
- START held high after DONE starts a new run on the next edge.
- Counters are DATABUS_WIDTH bits. Comparisons are unsigned. RX_DELAY+SAMPLES_PER_ECHO is computed at DATABUS_WIDTH+1 bits, so there is no overflow wrap.

Optional Feature:
NMR_QSW_EN.
- Defined: EN_QSW goes high for 2 cycles immediately following each TX_GATE falling edge, to damp coil ring-down. It is forced low if D_ACQ's ACQ_WND would overlap.
- Undefined: the EN_QSW port remains and is tied 0.

Test Plan:
- Basic run: PULSE90=4, DELAY_NO_ACQ=6, PULSE180=8, DELAY_WITH_ACQ=20, ECHO_PER_SCAN=3, SAMPLES_PER_ECHO=5, RX_DELAY=4, ECHO_SKIP=1, NUM_SCANS=1, T1_PULSE180=0 -> FSMSTAT high 94 cycles; TX_GATE pattern 4H/6L/(8H/20L)x3; ACQ_WND total 10 cycles at D_ACQ offsets 4-8 of echoes 1,2; DONE once.
- Phase cycling: same run with NUM_SCANS=4, PHASE_CYCLE=1, SCAN_DELAY=10 -> P90 phases 0,1,2,3; P180 phases 1,2,3,0; 4 SCAN_DONE pulses 104 cycles apart; SCAN_IDX 0..3.
- Window truncation: RX_DELAY=18, SAMPLES_PER_ECHO=5, DELAY_WITH_ACQ=20 -> ACQ_WND 2 cycles per echo, low during every P180.
- T1 prep: T1_PULSE180=8, T1_DELAY=50, NUM_SCANS=2 -> each scan starts 8H/50L before P90; T1 pulse phase = P180 phase.
- Abort/reset: ABORT asserted mid D_ACQ of echo 1 -> next edge all outputs 0, no DONE. Repeat with RESET -> same. START then ECHO_PER_SCAN=0 -> no run.
- NMR_QSW_EN build: basic run -> EN_QSW 2-cycle pulses after each of the 4 TX_GATE falls. Non-macro build -> EN_QSW constantly 0.

Source files
------------

// File: rtl/nmr_cpmg_multiscan_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : nmr_cpmg_multiscan_seq_if
// Description : Bundles the run-control, timing/count and sequencer output
//               signals of the CPMG multi-scan sequencer.
//               master : pulse-program host (drives START/ABORT/timings)
//               slave  : sequencer (drives FSMSTAT, TX/RX gating, status)
// Revision    : 1.0 - initial release
// ============================================================================
interface nmr_cpmg_multiscan_seq_if #(
  parameter int DATABUS_WIDTH = 32,
  parameter int PHASE_BITS    = 2,
  parameter int SCAN_WIDTH    = 16
);
  // run control
  logic                     START;
  logic                     ABORT;
  // sequence timing / counts (cycles of PULSEPROG_CLK)
  logic [DATABUS_WIDTH-1:0] T1_PULSE180;
  logic [DATABUS_WIDTH-1:0] T1_DELAY;
  logic [DATABUS_WIDTH-1:0] PULSE90;
  logic [DATABUS_WIDTH-1:0] DELAY_NO_ACQ;
  logic [DATABUS_WIDTH-1:0] PULSE180;
  logic [DATABUS_WIDTH-1:0] DELAY_WITH_ACQ;
  logic [DATABUS_WIDTH-1:0] ECHO_PER_SCAN;
  logic [DATABUS_WIDTH-1:0] SAMPLES_PER_ECHO;
  logic [DATABUS_WIDTH-1:0] RX_DELAY;
  logic [DATABUS_WIDTH-1:0] ECHO_SKIP;
  logic [DATABUS_WIDTH-1:0] SCAN_DELAY;
  logic [SCAN_WIDTH-1:0]    NUM_SCANS;
  logic                     PHASE_CYCLE;
  // sequencer outputs
  logic                     FSMSTAT;
  logic                     TX_GATE;
  logic [PHASE_BITS-1:0]    TX_PHASE;
  logic                     EN_RX;
  logic                     ACQ_WND;
  logic [SCAN_WIDTH-1:0]    SCAN_IDX;
  logic                     SCAN_DONE;
  logic                     DONE;
  logic                     EN_QSW;

  modport master (
    output START, ABORT, T1_PULSE180, T1_DELAY, PULSE90, DELAY_NO_ACQ, PULSE180,
           DELAY_WITH_ACQ, ECHO_PER_SCAN, SAMPLES_PER_ECHO, RX_DELAY, ECHO_SKIP,
           SCAN_DELAY, NUM_SCANS, PHASE_CYCLE,
    input  FSMSTAT, TX_GATE, TX_PHASE, EN_RX, ACQ_WND, SCAN_IDX, SCAN_DONE, DONE,
           EN_QSW
  );

  modport slave (
    input  START, ABORT, T1_PULSE180, T1_DELAY, PULSE90, DELAY_NO_ACQ, PULSE180,
           DELAY_WITH_ACQ, ECHO_PER_SCAN, SAMPLES_PER_ECHO, RX_DELAY, ECHO_SKIP,
           SCAN_DELAY, NUM_SCANS, PHASE_CYCLE,
    output FSMSTAT, TX_GATE, TX_PHASE, EN_RX, ACQ_WND, SCAN_IDX, SCAN_DONE, DONE,
           EN_QSW
  );
endinterface
`default_nettype wire

// File: rtl/nmr_cpmg_multiscan_seq.sv
`default_nettype none
// ============================================================================
// Module      : nmr_cpmg_multiscan_seq
// Description : CPMG pulse-program sequencer with multi-scan averaging,
//               per-scan phase cycling and optional T1 inversion-recovery
//               preparation. Every output is registered.
// Ports       : PULSEPROG_CLK - sole clock
//               RESET         - synchronous active-high reset
//               bus (slave)   - START/ABORT, latched timing/count inputs,
//                               FSMSTAT, TX_GATE, TX_PHASE, EN_RX, ACQ_WND,
//                               SCAN_IDX, SCAN_DONE, DONE, EN_QSW
// Build macro : NMR_QSW_EN - enables the Q-switch ring-down pulse on EN_QSW;
//               when undefined EN_QSW is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module nmr_cpmg_multiscan_seq #(
  parameter int DATABUS_WIDTH = 32,
  parameter int PHASE_BITS    = 2,
  parameter int SCAN_WIDTH    = 16
) (
  input logic                     PULSEPROG_CLK,
  input logic                     RESET,
  nmr_cpmg_multiscan_seq_if.slave bus
);
  localparam int DW = DATABUS_WIDTH;
  localparam int SW = SCAN_WIDTH;
  localparam int PB = PHASE_BITS;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_T1_180 = 3'd1, S_T1_DLY = 3'd2, S_P90 = 3'd3,
    S_D_NOACQ = 3'd4, S_P180 = 3'd5, S_D_ACQ = 3'd6, S_SCAN_WAIT = 3'd7
  } state_t;

  typedef struct packed {
    logic [DW-1:0] t1p, t1d, p90, dna, p180, dacq, eps, spe, rxd, skip, sdly;
    logic [SW-1:0] nscan;
    logic          pc;
  } cfg_t;

  state_t        state_q, state_d;
  cfg_t          cfg_q, cfg_d;
  logic [DW-1:0] cnt_q, cnt_d, echo_q, echo_d, len_cur;
  logic [SW-1:0] scan_q, scan_d;
  logic [PB-1:0] tx_phase_q, tx_phase_d, ph;
  logic [DW:0]   win_end;
  logic          fsmstat_q, fsmstat_d, tx_gate_q, tx_gate_d, en_rx_q, en_rx_d;
  logic          acq_q, acq_d, scan_done_q, scan_done_d, done_q, done_d;
  logic          qsw_q, qsw_d, state_last, end_scan, accept, pc_sel;

  function automatic logic [DW-1:0] clamp1(input logic [DW-1:0] v);
    return (v == '0) ? DW'(1) : v;
  endfunction

  // Duration of the current state; zero-length states run for one cycle.
  always_comb begin
    len_cur = DW'(1);
    case (state_q)
      S_T1_180:    len_cur = clamp1(cfg_q.t1p);
      S_T1_DLY:    len_cur = clamp1(cfg_q.t1d);
      S_P90:       len_cur = clamp1(cfg_q.p90);
      S_D_NOACQ:   len_cur = clamp1(cfg_q.dna);
      S_P180:      len_cur = clamp1(cfg_q.p180);
      S_D_ACQ:     len_cur = clamp1(cfg_q.dacq);
      S_SCAN_WAIT: len_cur = clamp1(cfg_q.sdly);
      default:     len_cur = DW'(1);
    endcase
  end

  assign state_last = (cnt_q == len_cur - DW'(1));
  assign accept     = (state_q == S_IDLE) && bus.START &&
                      (bus.ECHO_PER_SCAN != '0) && (bus.NUM_SCANS != '0);
  // Window end is one bit wider so RX_DELAY+SAMPLES_PER_ECHO cannot wrap.
  assign win_end    = {1'b0, cfg_q.rxd} + {1'b0, cfg_q.spe};

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    cnt_d       = cnt_q + DW'(1);
    echo_d      = echo_q;
    scan_d      = scan_q;
    done_d      = 1'b0;
    scan_done_d = 1'b0;
    end_scan    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          cfg_d   = '{bus.T1_PULSE180, bus.T1_DELAY, bus.PULSE90, bus.DELAY_NO_ACQ,
                      bus.PULSE180, bus.DELAY_WITH_ACQ, bus.ECHO_PER_SCAN,
                      bus.SAMPLES_PER_ECHO, bus.RX_DELAY, bus.ECHO_SKIP,
                      bus.SCAN_DELAY, bus.NUM_SCANS, bus.PHASE_CYCLE};
          echo_d  = '0;
          scan_d  = '0;
          state_d = (bus.T1_PULSE180 != '0) ? S_T1_180 : S_P90;
        end
      end
      S_T1_180:  if (state_last) begin cnt_d = '0; state_d = S_T1_DLY;  end
      S_T1_DLY:  if (state_last) begin cnt_d = '0; state_d = S_P90;     end
      S_P90:     if (state_last) begin cnt_d = '0; state_d = S_D_NOACQ; end
      S_D_NOACQ: if (state_last) begin cnt_d = '0; state_d = S_P180;    end
      S_P180:    if (state_last) begin cnt_d = '0; state_d = S_D_ACQ;   end
      S_D_ACQ: begin
        if (state_last) begin
          cnt_d = '0;
          if (echo_q == cfg_q.eps - DW'(1)) begin
            echo_d = '0;
            if (cfg_q.sdly != '0) state_d = S_SCAN_WAIT;
            else                  end_scan = 1'b1;
          end else begin
            echo_d  = echo_q + DW'(1);
            state_d = S_P180;
          end
        end
      end
      S_SCAN_WAIT: if (state_last) begin cnt_d = '0; end_scan = 1'b1; end
      default: state_d = S_IDLE;
    endcase

    if (end_scan) begin
      scan_done_d = 1'b1;
      if (scan_q == cfg_q.nscan - SW'(1)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        scan_d  = '0;
      end else begin
        scan_d  = scan_q + SW'(1);
        state_d = (cfg_q.t1p != '0) ? S_T1_180 : S_P90;
      end
    end

    // Abort wins over everything, including a START sampled in IDLE.
    if (bus.ABORT) begin
      state_d     = S_IDLE;
      cfg_d       = cfg_q;
      cnt_d       = '0;
      echo_d      = '0;
      scan_d      = '0;
      done_d      = 1'b0;
      scan_done_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they line up with it.
  always_comb begin
    pc_sel     = (state_q == S_IDLE) ? bus.PHASE_CYCLE : cfg_q.pc;
    ph         = pc_sel ? scan_d[PB-1:0] : '0;
    fsmstat_d  = (state_d != S_IDLE);
    tx_gate_d  = (state_d == S_T1_180) || (state_d == S_P90) || (state_d == S_P180);
    en_rx_d    = (state_d == S_D_ACQ);
    acq_d      = (state_d == S_D_ACQ) && (echo_d >= cfg_q.skip) &&
                 (cnt_d >= cfg_q.rxd) && ({1'b0, cnt_d} < win_end);
    tx_phase_d = tx_phase_q;
    if (state_d == S_P90)
      tx_phase_d = ph;
    else if ((state_d == S_P180) || (state_d == S_T1_180))
      tx_phase_d = ph + PB'(1);  // quadrature to the 90 pulse
    if (bus.ABORT)
      tx_phase_d = '0;
  end

`ifdef NMR_QSW_EN
  logic tx_gate_h_q;
  // Two cycles after every gate fall, unless the acquisition window is open.
  assign qsw_d = fsmstat_d && !tx_gate_d && (tx_gate_q || tx_gate_h_q) && !acq_d;
  always_ff @(posedge PULSEPROG_CLK) begin
    if (RESET) tx_gate_h_q <= 1'b0;
    else       tx_gate_h_q <= tx_gate_q;
  end
`else
  assign qsw_d = 1'b0;
`endif

  always_ff @(posedge PULSEPROG_CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      cnt_q       <= '0;
      echo_q      <= '0;
      scan_q      <= '0;
      tx_phase_q  <= '0;
      fsmstat_q   <= 1'b0;
      tx_gate_q   <= 1'b0;
      en_rx_q     <= 1'b0;
      acq_q       <= 1'b0;
      scan_done_q <= 1'b0;
      done_q      <= 1'b0;
      qsw_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      cnt_q       <= cnt_d;
      echo_q      <= echo_d;
      scan_q      <= scan_d;
      tx_phase_q  <= tx_phase_d;
      fsmstat_q   <= fsmstat_d;
      tx_gate_q   <= tx_gate_d;
      en_rx_q     <= en_rx_d;
      acq_q       <= acq_d;
      scan_done_q <= scan_done_d;
      done_q      <= done_d;
      qsw_q       <= qsw_d;
    end
  end

  assign bus.FSMSTAT   = fsmstat_q;
  assign bus.TX_GATE   = tx_gate_q;
  assign bus.TX_PHASE  = tx_phase_q;
  assign bus.EN_RX     = en_rx_q;
  assign bus.ACQ_WND   = acq_q;
  assign bus.SCAN_IDX  = scan_q;
  assign bus.SCAN_DONE = scan_done_q;
  assign bus.DONE      = done_q;
  assign bus.EN_QSW    = qsw_q;
endmodule
`default_nettype wire
